// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if
// Groups every non-clock signal of the multiply sequencer into one bundle.
// The bundle covers the request/result side (start, operands, busy, done,
// hi, lo) and the borrowed-ALU side (alu_req, alu_ctl, alu_a, alu_b,
// alu_result).
//
// Modports:
//   slave  - the sequencer itself. It takes start/a/b/alu_result and drives
//            everything else.
//   master - the surrounding pipeline. It issues requests, supplies the ALU
//            sum and reads the results.
interface mult_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             alu_req;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    modport slave (
        input  start, a, b, alu_result,
        output busy, done, hi, lo, alu_req, alu_ctl, alu_a, alu_b
    );

    modport master (
        output start, a, b, alu_result,
        input  busy, done, hi, lo, alu_req, alu_ctl, alu_a, alu_b
    );
endinterface

// File: rtl/mult_sequencer.sv
// mult_sequencer
// Multi-cycle unsigned shift-and-add multiplier that sits beside the EX
// stage. It borrows the shared datapath ALU for each partial-sum addition.
// The 2*WIDTH-bit product ends up in hi/lo, ready for mfhi/mflo-style reads.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - mult_sequencer_if.slave:
//              start/a/b     request and unsigned operands, sampled only in IDLE
//              busy/alu_req  high while iterating (EX mux selects our operands)
//              done          one-cycle pulse when hi/lo hold a new product
//              hi/lo         upper/lower product halves
//              alu_ctl       always ALU_ADD
//              alu_a/alu_b   ALU operands (zero in IDLE)
//              alu_result    combinational alu_a + alu_b from the shared ALU
module mult_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [3:0]  ALU_ADD = 4'b0000
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_sequencer_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CNT_W-1:0] cnt;
    logic             done;

    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             last_iter;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;

    assign last_iter = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and ALU operand drive. In RUN we add either the multiplicand
    // or zero to hi. With lo[0]=0 the ALU simply returns hi, so the no-add
    // case needs no separate path.
    always_comb begin
        state_next = state;
        alu_a      = '0;
        alu_b      = '0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                alu_a = hi;
                alu_b = lo[0] ? mcand : '0;
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The shared ALU has no carry port. Recover carry-out locally: an
    // unsigned add overflowed exactly when the wrapped sum is below an
    // addend.
    always_comb begin
        sum   = bus.alu_result;
        carry = (sum < hi);
    end

    // Datapath registers. Each iteration shifts the {carry, sum, lo} concat
    // right by one. The consumed multiplier bit drops off the bottom of lo,
    // and the finished product bits accumulate from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.a;
                        hi    <= '0;
                        lo    <= bus.b;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    {hi, lo} <= {carry, sum, lo[WIDTH-1:1]};
                    cnt      <= cnt + 1'b1;
                    if (last_iter) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.alu_req = (state == RUN);
    assign bus.done    = done;
    assign bus.hi      = hi;
    assign bus.lo      = lo;
    assign bus.alu_ctl = ALU_ADD;
    assign bus.alu_a   = alu_a;
    assign bus.alu_b   = alu_b;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer
// Scoreboard bench for mult_sequencer at WIDTH=32.
// Stimulus pushes the arithmetic product a*b into a queue. A monitor process
// pops the queue on every done pulse and compares it with {hi, lo}. The
// monitor also checks the ALU control lines on every cycle. The shared ALU
// is modelled as a plain combinational adder.
module tb_mult_sequencer;

    localparam int unsigned WIDTH   = 32;
    localparam logic [3:0]  ALU_ADD = 4'b0000;

    logic clk;
    logic rst_n;

    mult_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mult_sequencer #(
        .WIDTH   (WIDTH),
        .ALU_ADD (ALU_ADD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.alu_result = bus.alu_a + bus.alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: on every falling edge, check the ALU control lines. When done
    // is high, pop one expected product and compare it with {hi, lo}.
    always @(negedge clk) begin
        logic [2*WIDTH-1:0] exp_prod;
        checkOutput("alu_ctl", 64'(bus.alu_ctl), 64'(ALU_ADD));
        checkOutput("alu_req_vs_busy", 64'(bus.alu_req), 64'(bus.busy));
        if (!bus.busy) begin
            checkOutput("idle_alu_a", 64'(bus.alu_a), 64'd0);
            checkOutput("idle_alu_b", 64'(bus.alu_b), 64'd0);
        end
        if (bus.done) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_done: hi=0x%0h lo=0x%0h with empty scoreboard",
                         bus.hi, bus.lo);
            end else begin
                exp_prod = exp_q.pop_front();
                if ({bus.hi, bus.lo} !== exp_prod) begin
                    fails++;
                    $display("[TB] FAIL product: got 0x%0h, expected 0x%0h",
                             {bus.hi, bus.lo}, exp_prod);
                end
            end
        end
    end

    // Present one request for a single clock and record its product. The
    // task returns just after the accepting edge. It then scrambles the
    // operand inputs, because the sequencer must ignore later changes.
    task automatic issueOp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input bit expect_result);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        if (expect_result) exp_q.push_back(64'(av) * 64'(bv));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Sample each falling edge until done appears, with a bounded budget.
    // This counts busy-high cycles and the cycle on which done shows up.
    // It can optionally check that alu_b stays zero and inject a stray start
    // mid-run.
    task automatic waitDone(input bit zchk, input int poke_at,
                            output int busy_cnt, output int samples, output bit seen);
        busy_cnt = 0;
        samples  = 0;
        seen     = 1'b0;
        while (!seen && samples < 100) begin
            @(negedge clk);
            samples++;
            if (poke_at > 0 && samples == poke_at) begin
                bus.start = 1'b1;
                bus.a     = $urandom;
                bus.b     = $urandom;
            end else if (poke_at > 0 && samples == poke_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (zchk && bus.busy) checkOutput("run_alu_b_zero", 64'(bus.alu_b), 64'd0);
            if (bus.done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL done_timeout: no done after %0d cycles, required within %0d",
                     samples, WIDTH + 1);
        end
    endtask

    // done must appear WIDTH cycles after busy rises, and busy must be high
    // for exactly WIDTH cycles.
    task automatic checkTiming(input int busy_cnt, input int samples);
        checkOutput("busy_cycles", 64'(busy_cnt), 64'(WIDTH));
        checkOutput("latency", 64'(samples - 1), 64'(WIDTH));
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input bit zchk, input int poke_at);
        int  busy_cnt;
        int  samples;
        bit  seen;
        issueOp(av, bv, 1'b1);
        waitDone(zchk, poke_at, busy_cnt, samples, seen);
        checkTiming(busy_cnt, samples);
    endtask

    initial begin
        int  busy_cnt;
        int  samples;
        bit  seen;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        #3;
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("reset_lo", 64'(bus.lo), 64'd0);
        checkOutput("reset_alu_req", 64'(bus.alu_req), 64'd0);
        checkOutput("reset_alu_a", 64'(bus.alu_a), 64'd0);
        checkOutput("reset_alu_b", 64'(bus.alu_b), 64'd0);
        checkOutput("reset_alu_ctl", 64'(bus.alu_ctl), 64'(ALU_ADD));

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] directed products");
        applyStimulus(32'd3, 32'd5, 1'b0, 0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        applyStimulus(32'h8000_0000, 32'd2, 1'b0, 0);
        applyStimulus(32'h1234_5678, 32'd0, 1'b1, 0);

        $display("[TB] stray start mid-run");
        applyStimulus(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 5);

        $display("[TB] reset mid-run");
        issueOp(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
        checkOutput("midrst_done", 64'(bus.done), 64'd0);
        checkOutput("midrst_hi", 64'(bus.hi), 64'd0);
        checkOutput("midrst_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("post_rst_busy", 64'(bus.busy), 64'd0);
        applyStimulus(32'd1000, 32'd2000, 1'b0, 0);

        $display("[TB] back-to-back");
        issueOp(32'd11, 32'd13, 1'b1);
        waitDone(1'b0, 0, busy_cnt, samples, seen);
        checkTiming(busy_cnt, samples);
        bus.start = 1'b1;
        bus.a     = 32'd7;
        bus.b     = 32'd9;
        exp_q.push_back(64'd63);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("b2b_busy", 64'(bus.busy), 64'd1);
        checkOutput("b2b_done_drop", 64'(bus.done), 64'd0);
        waitDone(1'b0, 0, busy_cnt, samples, seen);
        checkTiming(busy_cnt, samples);
        checkOutput("b2b_lo", 64'(bus.lo), 64'h3F);

        $display("[TB] random products");
        for (int i = 0; i < 8; i++) begin
            applyStimulus($urandom, $urandom, 1'b0, 0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
